// File: rtl/ps2_frame_rx.sv
// Host-side PS/2 receive decoder: synchronizes and filters the device lines and
// assembles 11-bit frames into a one-deep valid/ready output register.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       overrun
);

    localparam int RUN_W = $clog2(FILTER_LEN);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]       clk_sync_q, data_sync_q;
    logic             filt_q, filt_prev_q;
    logic [RUN_W-1:0] run_q;
    logic             sample_evt, bit_val;

    // The filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    // NOTE: clocked state is always assigned with <= so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            run_q       <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            filt_prev_q <= filt_q;
            if (clk_sync_q[1] == filt_q) begin
                run_q <= '0;
            end else if (run_q == RUN_MAX) begin
                filt_q <= clk_sync_q[1];
                run_q  <= '0;
            end else begin
                run_q <= run_q + 1'b1;
            end
        end
    end

    assign sample_evt = filt_prev_q & ~filt_q;
    assign bit_val    = data_sync_q[1];

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            err_parity_q, err_parity_d;
    logic            err_frame_q, err_frame_d;
    logic            err_timeout_q, err_timeout_d;
    logic            overrun_q, overrun_d;
    logic            parity_ok;

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        par_d         = par_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        err_parity_d  = 1'b0;
        err_frame_d   = 1'b0;
        err_timeout_d = 1'b0;
        overrun_d     = 1'b0;
        parity_ok     = ^{shreg_q, par_q};

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        if (state_q == S_IDLE || sample_evt) to_cnt_d = '0;
        else                                 to_cnt_d = to_cnt_q + 1'b1;

        if (state_q != S_IDLE && to_cnt_q == TO_MAX) begin
            err_timeout_d = 1'b1;
            state_d       = S_IDLE;
            to_cnt_d      = '0;
        end else if (sample_evt) begin
            case (state_q)
                S_IDLE: begin
                    if (!bit_val) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shreg_d   = {bit_val, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = bit_val;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    err_parity_d = ~parity_ok;
                    err_frame_d  = ~bit_val;
                    if (bit_val && parity_ok) begin
                        // A same-cycle consume frees the register for the new byte.
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            par_q         <= 1'b0;
            to_cnt_q      <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            par_q         <= par_d;
            to_cnt_q      <= to_cnt_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            err_parity_q  <= err_parity_d;
            err_frame_q   <= err_frame_d;
            err_timeout_q <= err_timeout_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign err_parity  = err_parity_q;
    assign err_frame   = err_frame_q;
    assign err_timeout = err_timeout_q;
    assign overrun     = overrun_q;

endmodule
